// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam int DEF_DRAIN_CYC = 3;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the core datapath (master) and the sequencing controller (slave).
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             insert_nop;
    logic             br_taken;
    logic             halt_dec;
    logic             dmem_stall;
    logic             pc_en;
    logic             fd_en;
    logic             fd_nop;
    logic             de_en;
    logic             de_nop;
    logic             em_en;
    logic             mw_en;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output insert_nop, br_taken, halt_dec, dmem_stall,
        input  pc_en, fd_en, fd_nop, de_en, de_nop, em_en, mw_en, halted,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  insert_nop, br_taken, halt_dec, dmem_stall,
        output pc_en, fd_en, fd_nop, de_en, de_nop, em_en, mw_en, halted,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, bubble/flush selects, halt drain, perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYC = DEF_DRAIN_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam int DW = $clog2(DRAIN_CYC + 1);

    state_t          state_reg;
    logic [DW-1:0]   drain_ctr_reg;
    logic            run_adv;
    logic [1:0]      cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    // A memory stall freezes everything, including the drain countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            drain_ctr_reg <= '0;
        end else if (!bus.dmem_stall) begin
            case (state_reg)
                RUN: begin
                    if (!bus.insert_nop && bus.halt_dec) begin
                        state_reg     <= DRAIN;
                        drain_ctr_reg <= DW'(DRAIN_CYC);
                    end
                end
                DRAIN: begin
                    if (drain_ctr_reg == DW'(1)) begin
                        state_reg     <= HALTED;
                        drain_ctr_reg <= '0;
                    end else begin
                        drain_ctr_reg <= drain_ctr_reg - DW'(1);
                    end
                end
                HALTED: begin
                    state_reg <= HALTED;
                end
                default: begin
                    state_reg     <= RUN;
                    drain_ctr_reg <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.pc_en  = 1'b0;
        bus.fd_en  = 1'b0;
        bus.fd_nop = 1'b0;
        bus.de_en  = 1'b0;
        bus.de_nop = 1'b0;
        bus.em_en  = 1'b0;
        bus.mw_en  = 1'b0;
        bus.halted = 1'b0;
        if (rst) begin
            // Load NOPs into every pipe register while the PC is held.
            bus.fd_en  = 1'b1;
            bus.fd_nop = 1'b1;
            bus.de_en  = 1'b1;
            bus.de_nop = 1'b1;
            bus.em_en  = 1'b1;
            bus.mw_en  = 1'b1;
        end else if (state_reg == HALTED) begin
            bus.halted = 1'b1;
        end else if (!bus.dmem_stall) begin
            bus.em_en = 1'b1;
            bus.mw_en = 1'b1;
            bus.de_en = 1'b1;
            if (state_reg == DRAIN) begin
                bus.fd_en  = 1'b1;
                bus.fd_nop = 1'b1;
                bus.de_nop = 1'b1;
            end else if (bus.insert_nop) begin
                bus.de_nop = 1'b1;
            end else if (bus.halt_dec) begin
                bus.fd_en  = 1'b1;
                bus.fd_nop = 1'b1;
            end else if (bus.br_taken) begin
                bus.pc_en  = 1'b1;
                bus.fd_en  = 1'b1;
                bus.fd_nop = 1'b1;
            end else begin
                bus.pc_en = 1'b1;
                bus.fd_en = 1'b1;
            end
        end
    end

    assign run_adv    = (state_reg == RUN) && !rst && !bus.dmem_stall;
    assign cnt_inc[0] = run_adv && bus.insert_nop;
    assign cnt_inc[1] = run_adv && !bus.insert_nop && !bus.halt_dec && bus.br_taken;

    // Index 0 counts hazard bubbles, index 1 counts branch flushes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_cnt #(
                .W(CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.stall_cnt = cnt_val[0];
    assign bus.flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl with 4-bit counters; expected rows queued at drive time.
module tb_pipe_ctrl;

    localparam int CW = 4;

    // ctl order: {pc_en, fd_en, fd_nop, de_en, de_nop, em_en, mw_en, halted}
    localparam logic [7:0] C_RST    = 8'b0111_1110;
    localparam logic [7:0] C_NORMAL = 8'b1101_0110;
    localparam logic [7:0] C_FREEZE = 8'b0000_0000;
    localparam logic [7:0] C_BUBBLE = 8'b0001_1110;
    localparam logic [7:0] C_HALTD  = 8'b0111_0110;
    localparam logic [7:0] C_BRANCH = 8'b1111_0110;
    localparam logic [7:0] C_DRAIN  = 8'b0111_1110;
    localparam logic [7:0] C_HALTED = 8'b0000_0001;

    // in order: {rst, insert_nop, br_taken, halt_dec, dmem_stall}
    typedef struct packed {
        logic [4:0]    in;
        logic [7:0]    ctl;
        logic          chk_cnt;
        logic [CW-1:0] st;
        logic [CW-1:0] fl;
    } row_t;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    row_t exp_q[$];

    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(
        .DRAIN_CYC (3),
        .CNT_W     (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(logic [4:0] in, logic [7:0] ctl, logic chk, int st, int fl);
        row_t r;
        r.in      = in;
        r.ctl     = ctl;
        r.chk_cnt = chk;
        r.st      = CW'(st);
        r.fl      = CW'(fl);
        return r;
    endfunction

    function automatic logic [7:0] ctl_obs();
        return {bus.pc_en, bus.fd_en, bus.fd_nop, bus.de_en, bus.de_nop,
                bus.em_en, bus.mw_en, bus.halted};
    endfunction

    task automatic drive_row(input row_t r);
        @(negedge clk);
        rst            = r.in[4];
        bus.insert_nop = r.in[3];
        bus.br_taken   = r.in[2];
        bus.halt_dec   = r.in[1];
        bus.dmem_stall = r.in[0];
        exp_q.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        bus.insert_nop = 1'b0;
        bus.br_taken   = 1'b0;
        bus.halt_dec   = 1'b0;
        bus.dmem_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        row_t plan[$];
        row_t e;
        plan.push_back(mk(5'b11111, C_RST, 1'b0, 0, 0));
        plan.push_back(mk(5'b11111, C_RST, 1'b1, 0, 0));
        plan.push_back(mk(5'b00000, C_NORMAL, 1'b1, 0, 0));
        foreach (plan[i]) begin
            drive_row(plan[i]);
            #4;
            e = exp_q.pop_front();
            n_cmp++;
            if (ctl_obs() !== e.ctl || (e.chk_cnt && {bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl})) begin
                n_bad++;
                $display("FAIL reset row %0d: got ctl=%b st=%0d fl=%0d, want ctl=%b st=%0d fl=%0d",
                         i, ctl_obs(), bus.stall_cnt, bus.flush_cnt, e.ctl, e.st, e.fl);
            end
            $display("reset row %0d: in=%b ctl=%b st=%0d fl=%0d", i, e.in, ctl_obs(), bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_hazard();
        row_t plan[$];
        row_t e;
        do_reset();
        plan.push_back(mk(5'b00000, C_NORMAL, 1'b1, 0, 0));
        plan.push_back(mk(5'b01000, C_BUBBLE, 1'b1, 0, 0));
        plan.push_back(mk(5'b01000, C_BUBBLE, 1'b1, 1, 0));
        plan.push_back(mk(5'b00000, C_NORMAL, 1'b1, 2, 0));
        foreach (plan[i]) begin
            drive_row(plan[i]);
            #4;
            e = exp_q.pop_front();
            n_cmp++;
            if (ctl_obs() !== e.ctl || {bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
                n_bad++;
                $display("FAIL hazard row %0d: got ctl=%b st=%0d fl=%0d, want ctl=%b st=%0d fl=%0d",
                         i, ctl_obs(), bus.stall_cnt, bus.flush_cnt, e.ctl, e.st, e.fl);
            end
            $display("hazard row %0d: in=%b ctl=%b st=%0d fl=%0d", i, e.in, ctl_obs(), bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_branch_vs_hazard();
        row_t plan[$];
        row_t e;
        do_reset();
        plan.push_back(mk(5'b01100, C_BUBBLE, 1'b1, 0, 0));
        plan.push_back(mk(5'b00100, C_BRANCH, 1'b1, 1, 0));
        plan.push_back(mk(5'b00000, C_NORMAL, 1'b1, 1, 1));
        foreach (plan[i]) begin
            drive_row(plan[i]);
            #4;
            e = exp_q.pop_front();
            n_cmp++;
            if (ctl_obs() !== e.ctl || {bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
                n_bad++;
                $display("FAIL branch row %0d: got ctl=%b st=%0d fl=%0d, want ctl=%b st=%0d fl=%0d",
                         i, ctl_obs(), bus.stall_cnt, bus.flush_cnt, e.ctl, e.st, e.fl);
            end
            $display("branch row %0d: in=%b ctl=%b st=%0d fl=%0d", i, e.in, ctl_obs(), bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_halt_drain();
        row_t plan[$];
        row_t e;
        do_reset();
        plan.push_back(mk(5'b00010, C_HALTD, 1'b1, 0, 0));
        for (int k = 0; k < 3; k++) plan.push_back(mk(5'b01110, C_DRAIN, 1'b1, 0, 0));
        for (int k = 0; k < 6; k++) plan.push_back(mk({1'b0, 4'($urandom)}, C_HALTED, 1'b1, 0, 0));
        plan.push_back(mk(5'b11111, C_RST, 1'b1, 0, 0));
        plan.push_back(mk(5'b00000, C_NORMAL, 1'b1, 0, 0));
        foreach (plan[i]) begin
            drive_row(plan[i]);
            #4;
            e = exp_q.pop_front();
            n_cmp++;
            if (ctl_obs() !== e.ctl || {bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
                n_bad++;
                $display("FAIL halt row %0d: got ctl=%b st=%0d fl=%0d, want ctl=%b st=%0d fl=%0d",
                         i, ctl_obs(), bus.stall_cnt, bus.flush_cnt, e.ctl, e.st, e.fl);
            end
            $display("halt row %0d: in=%b ctl=%b st=%0d fl=%0d", i, e.in, ctl_obs(), bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_dmem_drain();
        row_t plan[$];
        row_t e;
        do_reset();
        plan.push_back(mk(5'b01111, C_FREEZE, 1'b1, 0, 0));
        plan.push_back(mk(5'b01000, C_BUBBLE, 1'b1, 0, 0));
        plan.push_back(mk(5'b00100, C_BRANCH, 1'b1, 1, 0));
        plan.push_back(mk(5'b00010, C_HALTD,  1'b1, 1, 1));
        plan.push_back(mk(5'b00000, C_DRAIN,  1'b1, 1, 1));
        plan.push_back(mk(5'b00001, C_FREEZE, 1'b1, 1, 1));
        plan.push_back(mk(5'b01101, C_FREEZE, 1'b1, 1, 1));
        plan.push_back(mk(5'b00000, C_DRAIN,  1'b1, 1, 1));
        plan.push_back(mk(5'b00000, C_DRAIN,  1'b1, 1, 1));
        plan.push_back(mk(5'b00000, C_HALTED, 1'b1, 1, 1));
        foreach (plan[i]) begin
            drive_row(plan[i]);
            #4;
            e = exp_q.pop_front();
            n_cmp++;
            if (ctl_obs() !== e.ctl || {bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
                n_bad++;
                $display("FAIL dmem row %0d: got ctl=%b st=%0d fl=%0d, want ctl=%b st=%0d fl=%0d",
                         i, ctl_obs(), bus.stall_cnt, bus.flush_cnt, e.ctl, e.st, e.fl);
            end
            $display("dmem row %0d: in=%b ctl=%b st=%0d fl=%0d", i, e.in, ctl_obs(), bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_saturation();
        row_t plan[$];
        row_t e;
        do_reset();
        for (int k = 0; k < 20; k++) plan.push_back(mk(5'b01000, C_BUBBLE, 1'b1, (k > 15) ? 15 : k, 0));
        plan.push_back(mk(5'b00000, C_NORMAL, 1'b1, 15, 0));
        foreach (plan[i]) begin
            drive_row(plan[i]);
            #4;
            e = exp_q.pop_front();
            n_cmp++;
            if (ctl_obs() !== e.ctl || {bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
                n_bad++;
                $display("FAIL saturate row %0d: got ctl=%b st=%0d fl=%0d, want ctl=%b st=%0d fl=%0d",
                         i, ctl_obs(), bus.stall_cnt, bus.flush_cnt, e.ctl, e.st, e.fl);
            end
            $display("saturate row %0d: in=%b ctl=%b st=%0d fl=%0d", i, e.in, ctl_obs(), bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_back_to_back();
        row_t plan[$];
        row_t e;
        do_reset();
        for (int k = 0; k < 3; k++) plan.push_back(mk(5'b00100, C_BRANCH, 1'b1, 0, k));
        plan.push_back(mk(5'b00000, C_NORMAL, 1'b1, 0, 3));
        foreach (plan[i]) begin
            drive_row(plan[i]);
            #4;
            e = exp_q.pop_front();
            n_cmp++;
            if (ctl_obs() !== e.ctl || {bus.stall_cnt, bus.flush_cnt} !== {e.st, e.fl}) begin
                n_bad++;
                $display("FAIL b2b row %0d: got ctl=%b st=%0d fl=%0d, want ctl=%b st=%0d fl=%0d",
                         i, ctl_obs(), bus.stall_cnt, bus.flush_cnt, e.ctl, e.st, e.fl);
            end
            $display("b2b row %0d: in=%b ctl=%b st=%0d fl=%0d", i, e.in, ctl_obs(), bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.insert_nop = 1'b1;
        bus.br_taken   = 1'b1;
        bus.halt_dec   = 1'b1;
        bus.dmem_stall = 1'b1;
        test_reset();
        test_hazard();
        test_branch_vs_hazard();
        test_halt_drain();
        test_dmem_drain();
        test_saturation();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Consumes the hazard unit's stall request (insert_nop), the decode-resolved branch/jump flush request, the data-memory stall and the decoded halt.
- Produces per-stage pipeline-register write enables and NOP-injection selects (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Owns the halt-drain state machine and saturating stall/flush performance counters.

Parameters:
- DRAIN_CYC, 3, cycles the pipe keeps advancing after halt decode so older instructions retire (ID/EX, EX/MEM, MEM/WB).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- insert_nop  in  1  RAW hazard stall request from hazard unit
- br_taken  in  1  branch/jump taken, resolved in decode, valid for one cycle
- halt_dec  in  1  HALT instruction present in decode
- dmem_stall  in  1  data memory not ready; freeze whole pipe
- pc_en  out  1  PC register write enable
- fd_en  out  1  IF/ID write enable
- fd_nop  out  1  IF/ID loads NOP instead of fetched instruction
- de_en  out  1  ID/EX write enable
- de_nop  out  1  ID/EX loads NOP (bubble)
- em_en  out  1  EX/MEM write enable
- mw_en  out  1  MEM/WB write enable
- halted  out  1  pipe fully drained and stopped
- stall_cnt  out  CNT_W  count of hazard-bubble cycles
- flush_cnt  out  CNT_W  count of branch-flush cycles

Behaviour:
- States: RUN, DRAIN, HALTED. Register drain_ctr is $clog2(DRAIN_CYC+1) bits.
- State, drain_ctr and counters are registered. Enable/NOP outputs are combinational from state and inputs.
- rst=1 (overrides everything):
  - Combinational outputs: pc_en=0, all stage *_en=1, fd_nop=de_nop=1, halted=0, so pipe registers load NOPs.
  - Next state RUN, drain_ctr=0, stall_cnt=0, flush_cnt=0. Counter outputs read 0 the cycle after rst.
- Priority within RUN: dmem_stall > insert_nop > halt_dec > br_taken > normal.
- RUN outputs by case:
  - dmem_stall=1: all *_en=0, nops=0, no counter change, state held. Applies in DRAIN too: drain_ctr held.
  - insert_nop=1: pc_en=0, fd_en=0, de_en=1, de_nop=1, em_en=mw_en=1. stall_cnt+1. br_taken and halt_dec ignored this cycle; decode re-presents them.
  - halt_dec=1: pc_en=0, fd_en=1, fd_nop=1, de_en=1, de_nop=0 (HALT itself advances), em/mw=1. Next state DRAIN, drain_ctr=DRAIN_CYC.
  - br_taken=1: pc_en=1, fd_en=1, fd_nop=1 (squash wrong-path fetch), de_en=1, de_nop=0, em/mw=1. flush_cnt+1.
  - Normal: all *_en=1, nops=0.
- DRAIN:
  - Outputs: pc_en=0, fd_en=1, fd_nop=1, de_en=1, de_nop=1, em/mw=1. insert_nop, br_taken, halt_dec ignored.
  - drain_ctr decrements each non-dmem_stall cycle; when it reaches 1 and decrements, next state HALTED.
  - Total: exactly DRAIN_CYC advancing cycles in DRAIN.
- HALTED: all *_en=0, nops=0, halted=1. Leaves only on rst.
- Counters saturate at 2^CNT_W-1 (no wrap) and hold during dmem_stall.
- insert_nop held N cycles → exactly N bubbles, pc_en=0 for N cycles, stall_cnt += N.

Decomposition:
- Package pipe_ctrl_pkg: state encoding constants (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10) and default DRAIN_CYC.
- One sub-module: sat_cnt (parameter W; inputs clk, rst, inc; output count), instantiated twice.

Test Plan:
- Reset: hold rst 2 cycles with all inputs 1 → during rst pc_en=0, fd_nop=de_nop=1; next cycle state RUN, stall_cnt=flush_cnt=0, halted=0.
- Hazard: insert_nop=1 for 2 cycles in RUN → pc_en=fd_en=0 and de_nop=1 both cycles; stall_cnt=2; cycle 3 all enables 1.
- Branch vs hazard: insert_nop=1 with br_taken=1 → bubble only, flush_cnt=0. Next cycle br_taken=1 alone → fd_nop=1, pc_en=1, flush_cnt=1.
- Halt drain: halt_dec=1 → 3 DRAIN cycles with de_nop=1, pc_en=0. halted=1 on 4th cycle after halt; all *_en=0; holds through random inputs until rst.
- dmem_stall mid-drain: assert dmem_stall 2 cycles in DRAIN → all *_en=0; halted asserts 2 cycles later than without stall; counters unchanged.
- Saturation with CNT_W=4: insert_nop held 20 cycles → stall_cnt stops at 15.
